mmio_responder: RTL

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped responder: passes RAM accesses through to an external
// synchronous RAM and answers IO accesses from a small register set.
// The IO registers are LED, synchronised switches, and a periodic timer
// with compare/match and a read-to-clear status flag.
// Every read returns its data exactly one cycle after the request.
//
// Response-select FSM
//   state     | meaning
//   RESP_NONE | no read last cycle; read_data is driven to zero
//   RESP_RAM  | RAM read last cycle; read_data follows ram_dout
//   RESP_IO   | IO read last cycle; read_data is the captured IO value
module mmio_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  sw,
    output logic        ram_write,
    output logic [15:0] read_data,
    output logic [7:0]  led,
    output logic        timer_irq
);

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;

    localparam logic [8:0] ADDR_LED    = 9'h100;
    localparam logic [8:0] ADDR_SW     = 9'h140;
    localparam logic [8:0] ADDR_COUNT  = 9'h180;
    localparam logic [8:0] ADDR_CMP    = 9'h181;
    localparam logic [8:0] ADDR_STATUS = 9'h182;
    localparam logic [8:0] ADDR_CTRL   = 9'h183;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_RAM  = 2'd1,
        RESP_IO   = 2'd2
    } resp_t;

    resp_t resp_q;
    resp_t resp_d;

    logic        is_read;
    logic        is_write;
    logic        io_sel;

    logic        wr_led;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_ctrl;
    logic        rd_status;

    logic [7:0]  led_q;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [15:0] cmp_q;
    logic        enable_q;
    logic        flag_q;
    logic        flag_d;
    logic        match;

    logic [SYNC_STAGES-1:0][7:0] sw_pipe;
    logic [7:0]  sw_sync;

    logic [15:0] io_value;
    logic [15:0] io_rdata_q;

    // Command decode shared by the write strobes and the read path.
    always_comb begin
        is_read   = (mem_cmd == CMD_READ);
        is_write  = (mem_cmd == CMD_WRITE);
        io_sel    = mem_addr[8];
        wr_led    = is_write && (mem_addr == ADDR_LED);
        wr_count  = is_write && (mem_addr == ADDR_COUNT);
        wr_cmp    = is_write && (mem_addr == ADDR_CMP);
        wr_ctrl   = is_write && (mem_addr == ADDR_CTRL);
        rd_status = is_read  && (mem_addr == ADDR_STATUS);
    end

    assign ram_write = is_write && !io_sel;

    // Switch synchroniser; only the last stage is ever looked at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_pipe <= '0;
        end else begin
            sw_pipe <= {sw_pipe[SYNC_STAGES-2:0], sw};
        end
    end

    assign sw_sync = sw_pipe[SYNC_STAGES-1];

    // Timer next state: a bus write to COUNT overrides both the match
    // reload and the increment; the match itself still sets the flag.
    always_comb begin
        match   = enable_q && (count_q == cmp_q);
        count_d = count_q;
        if (wr_count) begin
            count_d = write_data;
        end else if (match) begin
            count_d = 16'h0000;
        end else if (enable_q) begin
            count_d = count_q + 16'd1;
        end

        flag_d = flag_q;
        if (match) begin
            flag_d = 1'b1;
        end else if (rd_status) begin
            flag_d = 1'b0;
        end
    end

    // IO register file and timer state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q    <= 8'h00;
            count_q  <= 16'h0000;
            cmp_q    <= 16'h0000;
            enable_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            if (wr_led) begin
                led_q <= write_data[7:0];
            end
            if (wr_cmp) begin
                cmp_q <= write_data;
            end
            if (wr_ctrl) begin
                enable_q <= write_data[0];
            end
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    // IO read mux over pre-edge register values; unmapped addresses read zero.
    always_comb begin
        io_value = 16'h0000;
        case (mem_addr)
            ADDR_LED:    io_value = {8'h00, led_q};
            ADDR_SW:     io_value = {8'h00, sw_sync};
            ADDR_COUNT:  io_value = count_q;
            ADDR_CMP:    io_value = cmp_q;
            ADDR_STATUS: io_value = {15'h0000, flag_q};
            ADDR_CTRL:   io_value = {15'h0000, enable_q};
            default:     io_value = 16'h0000;
        endcase
    end

    // Capture IO read data so it is presented in the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_rdata_q <= 16'h0000;
        end else if (is_read && io_sel) begin
            io_rdata_q <= io_value;
        end
    end

    // Response-select state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_q <= RESP_NONE;
        end else begin
            resp_q <= resp_d;
        end
    end

    // Response-select next state and read_data steering.
    always_comb begin
        resp_d    = RESP_NONE;
        read_data = 16'h0000;
        if (is_read) begin
            resp_d = io_sel ? RESP_IO : RESP_RAM;
        end
        case (resp_q)
            RESP_RAM: read_data = ram_dout;
            RESP_IO:  read_data = io_rdata_q;
            default:  read_data = 16'h0000;
        endcase
    end

    assign led       = led_q;
    assign timer_irq = flag_q;

endmodule
